// File: rtl/key_encoder.sv
// Purpose: debounce eight active-low keys and encode the highest-priority press as a 3-bit code.
// Latency: valid rises after the (DEBOUNCE+2)th edge following the first edge that samples a key low.
// Backpressure: valid/ready output; a new event arriving while the output is still occupied is dropped and sets sticky overrun.
module key_encoder #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [7:0] key_i,
    input  logic       ready_i,
    output logic [2:0] code_o,
    output logic       multi_o,
    output logic       valid_o,
    output logic       overrun_o
);

    // A one-cycle debounce still needs a 1-bit counter so the port widths stay legal.
    localparam int               CNT_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_WAIT_RELEASE
    } state_e;

    // Two-flop synchronizer; idle value is all keys released.
    logic [7:0] key_meta_q;
    logic [7:0] key_sync_q;
    logic [7:0] pressed;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       snap_q, snap_d;
    logic             emit;

    logic [2:0] enc_code;
    logic       enc_multi;
    logic [3:0] ones;

    logic [2:0] code_q, code_d;
    logic       multi_q, multi_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;

    // Bring the asynchronous key lines into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_meta_q <= 8'hff;
            key_sync_q <= 8'hff;
        end else begin
            key_meta_q <= key_i;
            key_sync_q <= key_meta_q;
        end
    end

    assign pressed = ~key_sync_q;

    // Press/release tracking state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
        end
    end

    // Next-state logic: capture a snapshot, require it to hold, then require a full release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        emit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && (pressed != 8'h00)) begin
                    snap_d  = pressed;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                // Any change aborts; IDLE re-captures on the following edge.
                if (!enable_i || (pressed != snap_q)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    emit    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                // Enable is deliberately ignored here so a held key cannot re-fire.
                if (pressed != 8'h00) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Priority encode the snapshot (bit 0 wins) and flag multiple simultaneous keys.
    always_comb begin
        enc_code = 3'd0;
        ones     = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (snap_q[i]) begin
                enc_code = 3'(i);
            end
            ones = ones + {3'b000, snap_q[i]};
        end
        enc_multi = (ones > 4'd1);
    end

    // Output slot: load on emit when free or being drained, otherwise drop and flag overrun.
    always_comb begin
        code_d    = code_q;
        multi_d   = multi_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (emit) begin
            if (!valid_q || ready_i) begin
                code_d  = enc_code;
                multi_d = enc_multi;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            code_q    <= 3'd0;
            multi_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            code_q    <= code_d;
            multi_q   <= multi_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign code_o    = code_q;
    assign multi_o   = multi_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_key_encoder.sv
// Purpose: self-checking bench for key_encoder against a run-length reference model.
// Latency: model tracks outputs edge by edge; outputs compared on every falling edge.
// Backpressure: ready driven directed and randomly to exercise drain, back-to-back and overrun.
module tb_key_encoder;

    localparam int D = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enable  = 1'b1;
    logic       ready   = 1'b1;
    logic [7:0] key     = 8'h00;
    logic [2:0] code;
    logic       multi;
    logic       valid;
    logic       overrun;

    key_encoder #(.DEBOUNCE(D)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .enable_i  (enable),
        .key_i     (key),
        .ready_i   (ready),
        .code_o    (code),
        .multi_o   (multi),
        .valid_o   (valid),
        .overrun_o (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model thinks in run lengths: how many consecutive edges the same
    // non-zero snapshot has been seen (m_run, -1 = not tracking) and how many
    // consecutive all-released edges have been seen since the last event.
    logic [7:0] m_s1    = 8'hff;
    logic [7:0] m_s2    = 8'hff;
    bit         m_armed = 1'b1;
    int         m_run   = -1;
    int         m_rel   = 0;
    logic [7:0] m_snap  = 8'h00;
    logic       m_valid = 1'b0;
    logic [2:0] m_code  = 3'd0;
    logic       m_multi = 1'b0;
    logic       m_ovr   = 1'b0;
    logic [7:0] m_p;
    bit         m_emit;

    function automatic logic [2:0] lowest(input logic [7:0] v);
        int r = 0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = i;
        return 3'(r);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 8'hff; m_s2 = 8'hff; m_armed = 1'b1; m_run = -1; m_rel = 0;
            m_snap = 8'h00; m_valid = 1'b0; m_code = 3'd0; m_multi = 1'b0; m_ovr = 1'b0;
        end else begin
            m_p    = ~m_s2;
            m_emit = 1'b0;
            if (!m_armed) begin
                if (m_p != 8'h00) m_rel = 0;
                else begin
                    m_rel++;
                    if (m_rel == D) begin m_armed = 1'b1; m_rel = 0; end
                end
            end else if (m_run < 0) begin
                if (enable && m_p != 8'h00) begin m_snap = m_p; m_run = 0; end
            end else begin
                if (!enable || m_p != m_snap) m_run = -1;
                else begin
                    m_run++;
                    if (m_run == D) begin m_emit = 1'b1; m_run = -1; m_armed = 1'b0; m_rel = 0; end
                end
            end
            if (m_emit) begin
                if (!m_valid || ready) begin
                    m_code  = lowest(m_snap);
                    m_multi = ($countones(m_snap) > 1);
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = key;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("valid_vs_model",   32'(valid),   32'(m_valid));
            check("code_vs_model",    32'(code),    32'(m_code));
            check("multi_vs_model",   32'(multi),   32'(m_multi));
            check("overrun_vs_model", 32'(overrun), 32'(m_ovr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [7:0] k, input int hold, input int rel,
                         output int lat, output int nval, output logic [2:0] c, output logic m);
        lat = -1; nval = 0; c = 3'd0; m = 1'b0;
        key = k;
        for (int i = 1; i <= hold + rel; i++) begin
            if (i == hold + 1) key = 8'hff;
            @(posedge clk); #1;
            if (valid && lat < 0) begin lat = i; c = code; m = multi; end
            if (valid) nval++;
        end
    endtask

    task automatic wait_valid(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            if (valid) begin lat = i; break; end
        end
    endtask

    int         lat, nval, kind, hold, idx;
    logic [2:0] c;
    logic       m;
    logic [7:0] rk;

    initial begin
        // Reset with all keys pressed.
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        check("rst_code",    32'(code),    32'd0);
        check("rst_multi",   32'(multi),   32'd0);
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        wait_valid(20, lat);
        check("rst_first_latency", 32'(lat), 32'd7);
        check("rst_first_code",    32'(code), 32'd0);
        check("rst_first_multi",   32'(multi), 32'd1);
        key = 8'hff;
        repeat (10) @(posedge clk);
        #1;

        // Single press held long: exactly one event.
        press(8'hf7, 20, 10, lat, nval, c, m);
        check("single_latency", 32'(lat),  32'd7);
        check("single_code",    32'(c),    32'd3);
        check("single_multi",   32'(m),    32'd0);
        check("single_count",   32'(nval), 32'd1);

        press(8'hee, 10, 10, lat, nval, c, m);
        check("multi_code",  32'(c), 32'd0);
        check("multi_multi", 32'(m), 32'd1);
        press(8'h7f, 10, 10, lat, nval, c, m);
        check("key7_code",  32'(c), 32'd7);
        check("key7_multi", 32'(m), 32'd0);

        // Short glitch must be rejected.
        press(8'hfd, 3, 10, lat, nval, c, m);
        check("glitch_count", 32'(nval), 32'd0);

        // Enable low blocks acceptance; raising it with key held yields an event.
        enable = 1'b0;
        key    = 8'hfb;
        nval   = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (valid) nval++;
        end
        check("disabled_count", 32'(nval), 32'd0);
        enable = 1'b1;
        wait_valid(20, lat);
        check("enable_event", 32'(lat > 0), 32'd1);
        check("enable_code",  32'(code),    32'd2);
        key = 8'hff;
        repeat (10) @(posedge clk);
        #1;

        // Overrun with ready held low.
        ready = 1'b0;
        press(8'hdf, 10, 6, lat, nval, c, m);
        check("ovr_first_code", 32'(c), 32'd5);
        press(8'hbf, 10, 8, lat, nval, c, m);
        check("ovr_code",    32'(code),    32'd5);
        check("ovr_valid",   32'(valid),   32'd1);
        check("ovr_overrun", 32'(overrun), 32'd1);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        check("ovr_drain_valid",   32'(valid),   32'd0);
        check("ovr_drain_overrun", 32'(overrun), 32'd1);

        // Reset in WAIT_RELEASE with key held and event pending.
        key = 8'hef;
        wait_valid(20, lat);
        check("midrst_pre_valid", 32'(valid), 32'd1);
        check("midrst_pre_code",  32'(code),  32'd4);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_code",    32'(code),    32'd0);
        check("midrst_multi",   32'(multi),   32'd0);
        check("midrst_valid",   32'(valid),   32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;
        wait_valid(20, lat);
        check("midrst_latency", 32'(lat),  32'd7);
        check("midrst_code2",   32'(code), 32'd4);
        key = 8'hff;
        repeat (10) @(posedge clk);
        #1;

        // Randomized traffic; every cycle is compared against the model.
        rk = 8'hff;
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 3);
            idx  = $urandom_range(0, 7);
            case (kind)
                0:       rk = 8'hff;
                1:       rk = ~(8'h01 << idx);
                2:       rk = 8'($urandom);
                default: rk = rk ^ (8'h01 << idx);
            endcase
            key    = rk;
            enable = ($urandom_range(0, 7) != 0);
            hold   = $urandom_range(1, 12);
            for (int i = 0; i < hold; i++) begin
                ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end

        key = 8'hff;
        ready = 1'b1;
        enable = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
